mem_rd_arbiter: RTL and testbench

- Shares one fixed-latency, single-outstanding instruction/data memory read port between two requesters: port 0 is instruction fetch, port 1 is data load or debug read.
- Arbitrates, captures the winning address, issues a one-cycle read strobe to the memory and waits for its valid pulse.
- Routes the returned word back to the granted requester.
- A watchdog ends any access whose memory response never arrives and returns an error to the requester.

---
 rtl/mem_rd_arbiter.sv | 95 +++++++++
 tb/tb_mem_rd_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: two-port arbiter for a single-outstanding memory read port, with a response timeout.
module mem_rd_arbiter #(
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic [31:0] p0_addr,
  output logic        p0_gnt,
  output logic        p0_rvd,
  output logic [31:0] p0_data,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic [31:0] p1_addr,
  output logic        p1_gnt,
  output logic        p1_rvd,
  output logic [31:0] p1_data,
  output logic        p1_err,
  output logic        m_ren,
  output logic [31:0] m_addr,
  input  logic        m_rvd,
  input  logic [31:0] m_rdata,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;
  logic any_req, pick, tmo, done, take;
  logic last_q, last_d, win_q, win_d, m_ren_q, m_ren_d, busy_q, busy_d;
  logic [1:0] gnt_q, gnt_d, rvd_q, rvd_d, err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
  logic [31:0] m_addr_q, m_addr_d, p0_data_q, p0_data_d, p1_data_q, p1_data_d;
  assign any_req = p0_req | p1_req;
  assign pick = (p0_req & p1_req) ? (PRIO_MODE == 1 ? 1'b1 : ~last_q) : p1_req;
  assign tmo = cnt_q == 8'(TIMEOUT - 1);
  assign done = state_q == WAIT && (m_rvd || tmo);
  assign take = state_q == IDLE && any_req;
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q == IDLE ? (any_req ? ISSUE : IDLE) :
              state_q == ISSUE ? WAIT : (done ? IDLE : WAIT);
  end
  always_comb begin
    win_d     = take ? pick : win_q;
    last_d    = done ? win_q : last_q;
    cnt_d     = state_q == WAIT ? cnt_q + 8'd1 : 8'd0;
    m_addr_d  = take ? (pick ? p1_addr : p0_addr) : m_addr_q;
    m_ren_d   = take;
    gnt_d     = take ? (pick ? 2'b10 : 2'b01) : 2'b00;
    rvd_d     = done ? (win_q ? 2'b10 : 2'b01) : 2'b00;
    err_d     = (done && !m_rvd) ? rvd_d : 2'b00;
    p0_data_d = (rvd_d[0] && m_rvd) ? m_rdata : 32'd0;
    p1_data_d = (rvd_d[1] && m_rvd) ? m_rdata : 32'd0;
    busy_d    = state_d != IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      last_q    <= 1'b1;
      win_q     <= 1'b0;
      cnt_q     <= 8'd0;
      m_addr_q  <= 32'd0;
      m_ren_q   <= 1'b0;
      gnt_q     <= 2'b00;
      rvd_q     <= 2'b00;
      err_q     <= 2'b00;
      p0_data_q <= 32'd0;
      p1_data_q <= 32'd0;
      busy_q    <= 1'b0;
    end else begin
      last_q    <= last_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      m_addr_q  <= m_addr_d;
      m_ren_q   <= m_ren_d;
      gnt_q     <= gnt_d;
      rvd_q     <= rvd_d;
      err_q     <= err_d;
      p0_data_q <= p0_data_d;
      p1_data_q <= p1_data_d;
      busy_q    <= busy_d;
    end
  assign p0_gnt  = gnt_q[0];
  assign p1_gnt  = gnt_q[1];
  assign p0_rvd  = rvd_q[0];
  assign p1_rvd  = rvd_q[1];
  assign p0_err  = err_q[0];
  assign p1_err  = err_q[1];
  assign p0_data = p0_data_q;
  assign p1_data = p1_data_q;
  assign m_ren   = m_ren_q;
  assign m_addr  = m_addr_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_mem_rd_arbiter.sv
// tb_mem_rd_arbiter: directed checks of a round-robin and a fixed-priority arbiter sharing one stimulus.
module tb_mem_rd_arbiter;
  localparam int DELAY = 5;
  logic clk = 0, rst = 1;
  logic p0_req = 0, p1_req = 0, mem_on = 1, inj = 0;
  logic [31:0] p0_addr = 0, p1_addr = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input logic [31:0] a);
    return a == 32'd0 ? 32'h11111111 : a == 32'd4 ? 32'hDEADBEEF : a == 32'd8 ? 32'hCAFE0008 : 32'd0;
  endfunction
  for (genvar g = 0; g < 2; g++) begin : gi
    logic p0_gnt, p0_rvd, p0_err, p1_gnt, p1_rvd, p1_err, m_ren, m_rvd, busy;
    logic [31:0] p0_data, p1_data, m_addr, m_rdata;
    logic pend, mrvd;
    logic [2:0] mcnt;
    logic [31:0] maddr;
    int drops;
    mem_rd_arbiter #(.PRIO_MODE(g), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt), .p0_rvd(p0_rvd), .p0_data(p0_data), .p0_err(p0_err),
      .p1_req(p1_req), .p1_addr(p1_addr), .p1_gnt(p1_gnt), .p1_rvd(p1_rvd), .p1_data(p1_data), .p1_err(p1_err),
      .m_ren(m_ren), .m_addr(m_addr), .m_rvd(m_rvd), .m_rdata(m_rdata), .busy(busy));
    assign m_rvd = mrvd | inj;
    always @(posedge clk)
      if (rst) begin
        pend <= 0; mrvd <= 0; mcnt <= 0; maddr <= 0; m_rdata <= 0; drops <= 0;
      end else begin
        mrvd <= 0;
        m_rdata <= 0;
        if (pend) begin
          if (mcnt == 3'(DELAY - 1)) begin
            pend <= 0; mrvd <= 1; m_rdata <= word(maddr);
          end else mcnt <= mcnt + 3'd1;
        end
        if (m_ren) begin
          if (pend) drops <= drops + 1;
          else if (mem_on) begin pend <= 1; mcnt <= 3'd1; maddr <= m_addr; end
        end
      end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  int t[8];
  int n;
  initial begin
    step(2);
    chk("rst_zero0", 32'(|{gi[0].p0_gnt, gi[0].p0_rvd, gi[0].p0_err, gi[0].p1_gnt, gi[0].p1_rvd, gi[0].p1_err,
                           gi[0].m_ren, gi[0].busy, gi[0].p0_data, gi[0].p1_data, gi[0].m_addr}), 0);
    chk("rst_zero1", 32'(|{gi[1].p0_gnt, gi[1].p0_rvd, gi[1].p0_err, gi[1].p1_gnt, gi[1].p1_rvd, gi[1].p1_err,
                           gi[1].m_ren, gi[1].busy, gi[1].p0_data, gi[1].p1_data, gi[1].m_addr}), 0);
    rst = 0;
    step();
    chk("idle_no_req", 32'(gi[0].busy), 0);
    // single port-0 read
    p0_req = 1; p0_addr = 32'h4;
    step();
    chk("t1_gnt", 32'(gi[0].p0_gnt), 1);
    chk("t1_ren", 32'(gi[0].m_ren), 1);
    chk("t1_addr", gi[0].m_addr, 32'h4);
    chk("t1_busy", 32'(gi[0].busy), 1);
    chk("t1_p1gnt", 32'(gi[0].p1_gnt), 0);
    p0_req = 0;
    step();
    chk("t1_gnt_clr", 32'({gi[0].p0_gnt, gi[0].m_ren}), 0);
    chk("t1_addr_hold", gi[0].m_addr, 32'h4);
    step(4);
    chk("t1_mrvd", 32'(gi[0].m_rvd), 1);
    chk("t1_rvd_early", 32'(gi[0].p0_rvd), 0);
    step();
    chk("t1_rvd", 32'(gi[0].p0_rvd), 1);
    chk("t1_data", gi[0].p0_data, 32'hDEADBEEF);
    chk("t1_err", 32'(gi[0].p0_err), 0);
    chk("t1_busy_end", 32'(gi[0].busy), 0);
    chk("t1_p1_quiet", 32'({gi[0].p1_rvd, gi[0].p1_err}) | gi[0].p1_data, 0);
    step();
    chk("t1_rvd_clr", 32'(gi[0].p0_rvd), 0);
    chk("t1_data_clr", gi[0].p0_data, 0);
    // round-robin tie; port 0 was served last so port 1 goes first
    p0_req = 1; p0_addr = 32'h0; p1_req = 1; p1_addr = 32'h8;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t2_gnt0_%0d", i), 32'(gi[0].p0_gnt), 32'(i % 2));
      chk($sformatf("t2_gnt1_%0d", i), 32'(gi[0].p1_gnt), 32'(1 - i % 2));
      chk($sformatf("t2_addr_%0d", i), gi[0].m_addr, i % 2 ? 32'h0 : 32'h8);
      step(6);
      chk($sformatf("t2_rvd0_%0d", i), 32'(gi[0].p0_rvd), 32'(i % 2));
      chk($sformatf("t2_rvd1_%0d", i), 32'(gi[0].p1_rvd), 32'(1 - i % 2));
      chk($sformatf("t2_data_%0d", i), gi[0].p0_data | gi[0].p1_data, i % 2 ? 32'h11111111 : 32'hCAFE0008);
    end
    // fixed priority on the second instance
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t3_gnt1_%0d", i), 32'({gi[1].p1_gnt, gi[1].p0_gnt}), 32'h2);
      step(6);
      chk($sformatf("t3_rvd1_%0d", i), gi[1].p1_data, 32'hCAFE0008);
    end
    p1_req = 0;
    step();
    chk("t3_gnt0", 32'({gi[1].p1_gnt, gi[1].p0_gnt}), 32'h1);
    chk("t3_addr0", gi[1].m_addr, 32'h0);
    p0_req = 0;
    step(6);
    chk("t3_rvd0", 32'({gi[1].p1_rvd, gi[1].p0_rvd}), 32'h1);
    chk("t3_data0", gi[1].p0_data, 32'h11111111);
    // timeout: memory never answers
    mem_on = 0; p0_req = 1; p0_addr = 32'h4;
    step();
    chk("t4_gnt", 32'(gi[0].p0_gnt), 1);
    p0_req = 0;
    step(8);
    chk("t4_rvd_early", 32'(gi[0].p0_rvd), 0);
    chk("t4_busy", 32'(gi[0].busy), 1);
    step();
    chk("t4_rvd", 32'(gi[0].p0_rvd), 1);
    chk("t4_err", 32'(gi[0].p0_err), 1);
    chk("t4_data", gi[0].p0_data, 0);
    chk("t4_rvd_prio", 32'({gi[1].p0_rvd, gi[1].p0_err}), 32'h3);
    inj = 1;
    step();
    inj = 0;
    chk("t4_late_rvd", 32'({gi[0].p0_rvd, gi[0].p0_err, gi[0].p1_rvd, gi[0].busy}), 0);
    step();
    chk("t4_late_after", 32'({gi[0].p0_rvd, gi[0].p1_rvd, gi[0].busy}), 0);
    mem_on = 1;
    // reset during WAIT
    p0_req = 1; p0_addr = 32'h8;
    step();
    p0_req = 0;
    step(2);
    chk("t5_in_wait", 32'(gi[0].busy), 1);
    rst = 1;
    step();
    chk("t5_zero", 32'(|{gi[0].p0_gnt, gi[0].p0_rvd, gi[0].p0_err, gi[0].p1_gnt, gi[0].p1_rvd, gi[0].p1_err,
                         gi[0].m_ren, gi[0].busy, gi[0].p0_data, gi[0].p1_data, gi[0].m_addr}), 0);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("t5_no_rvd_%0d", i), 32'({gi[0].p0_rvd, gi[0].busy}), 0);
    end
    p0_req = 1; p0_addr = 32'h0; p1_req = 1; p1_addr = 32'h8;
    step();
    chk("t5_tie_rr", 32'({gi[0].p1_gnt, gi[0].p0_gnt}), 32'h1);
    chk("t5_tie_fp", 32'({gi[1].p1_gnt, gi[1].p0_gnt}), 32'h2);
    p0_req = 0; p1_req = 0;
    step(6);
    chk("t5_data_rr", gi[0].p0_data, 32'h11111111);
    chk("t5_data_fp", gi[1].p1_data, 32'hCAFE0008);
    // back-to-back throughput
    p0_req = 1; p0_addr = 32'h4; n = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (gi[0].m_ren && n < 8) begin t[n] = c; n++; end
    end
    p0_req = 0;
    chk("t6_count", 32'(n >= 5), 1);
    chk("t6_first", 32'(t[0]), 1);
    for (int i = 1; i < 5; i++) chk($sformatf("t6_period_%0d", i), 32'(t[i] - t[i-1]), DELAY + 2);
    step(10);
    chk("t6_drops", 32'(gi[0].drops), 0);
    chk("t6_idle", 32'(gi[0].busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
